// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl: schedules one shared freq_div among NREQ requesters.
// A requester is picked round-robin, the divider is loaded with a one-cycle
// pl pulse, and en stays high while the div_do toggles are counted. At the
// end of the burst the divider is released, done or abort pulses, and the
// controller returns to IDLE to arbitrate again.
//
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   req              per-requester request level
//   req_div/req_cnt  packed divisor (N bits) / toggle count (CW bits) per requester
//   grant            one-hot grant, zero when idle
//   done/abort       one-cycle burst completion / early-drop pulses
//   busy             high outside IDLE
//   div_en/pl/di     drive the freq_div instance
//   div_do           freq_div output, counted in toggles
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches divisor/count
// LOAD  | one cycle of div_pl with div_di = latched divisor
// RUN   | divider enabled, counting div_do toggles
// DONE  | one cycle: divider released, done/abort pulse, pointer update
module freq_div_ctrl #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int CW   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*N-1:0]  req_div,
    input  logic [NREQ*CW-1:0] req_cnt,
    output logic [NREQ-1:0]    grant,
    output logic               done,
    output logic               abort,
    output logic               busy,
    output logic               div_en,
    output logic               div_pl,
    output logic [N-1:0]       div_di,
    input  logic               div_do
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic            ptr_vld_q;
    logic [IW-1:0]   idx_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   tcnt_q;
    logic [CW-1:0]   tcnt_d;
    logic            do_q;

    logic [NREQ-1:0] grant_q;
    logic            done_q;
    logic            abort_q;
    logic            busy_q;
    logic            en_q;
    logic            pl_q;
    logic [N-1:0]    di_q;

    logic            sel_vld;
    logic [IW-1:0]   sel_idx;
    logic [N-1:0]    sel_div;
    logic [CW-1:0]   sel_cnt;
    int              start;
    int              j;
    logic            toggle;
    logic            reached;
    logic            req_g;

    // Round-robin search from ptr+1 with wrap. Until the first burst has been
    // served the search starts at 0 so requester 0 wins first after reset.
    // Iterating downward lets the lowest offset from the start win.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        j       = 0;
        start   = ptr_vld_q ? int'(ptr_q) + 1 : 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (start + k) % NREQ;
            if (req[j]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(j);
            end
        end
        sel_div = req_div[int'(sel_idx)*N +: N];
        if (sel_div == '0) begin
            sel_div = N'(1);
        end
        sel_cnt = req_cnt[int'(sel_idx)*CW +: CW];
    end

    assign req_g   = req[idx_q];
    assign toggle  = div_do ^ do_q;
    assign tcnt_d  = (tcnt_q == '1) ? tcnt_q : tcnt_q + {{(CW-1){1'b0}}, toggle};
    // Completion is judged on the updated count so a final toggle that lands
    // with the request drop still counts as done.
    assign reached = (cnt_q != '0) && (tcnt_d >= cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            ptr_vld_q <= 1'b0;
            idx_q     <= '0;
            cnt_q     <= '0;
            tcnt_q    <= '0;
            do_q      <= 1'b0;
            grant_q   <= '0;
            done_q    <= 1'b0;
            abort_q   <= 1'b0;
            busy_q    <= 1'b0;
            en_q      <= 1'b0;
            pl_q      <= 1'b0;
            di_q      <= '0;
        end else begin
            do_q    <= div_do;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            pl_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sel_vld) begin
                        idx_q   <= sel_idx;
                        cnt_q   <= sel_cnt;
                        di_q    <= sel_div;
                        grant_q <= NREQ'(1) << sel_idx;
                        en_q    <= 1'b1;
                        pl_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    tcnt_q <= '0;
                    if (req_g) begin
                        state_q <= RUN;
                    end else begin
                        en_q    <= 1'b0;
                        grant_q <= '0;
                        abort_q <= (cnt_q != '0);
                        done_q  <= (cnt_q == '0);
                        state_q <= DONE;
                    end
                end
                RUN: begin
                    tcnt_q <= tcnt_d;
                    if (reached || !req_g) begin
                        en_q    <= 1'b0;
                        grant_q <= '0;
                        done_q  <= reached || (cnt_q == '0);
                        abort_q <= !reached && (cnt_q != '0);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ptr_q     <= idx_q;
                    ptr_vld_q <= 1'b1;
                    busy_q    <= 1'b0;
                    di_q      <= '0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant  = grant_q;
    assign done   = done_q;
    assign abort  = abort_q;
    assign busy   = busy_q;
    assign div_en = en_q;
    assign div_pl = pl_q;
    assign div_di = di_q;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed testbench for freq_div_ctrl (N=16, NREQ=4, CW=8).
// The bench plays the role of freq_div by driving div_do by hand.
module tb_freq_div_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [63:0] req_div;
    logic [31:0] req_cnt;
    logic [3:0]  grant;
    logic        done;
    logic        abort;
    logic        busy;
    logic        div_en;
    logic        div_pl;
    logic [15:0] div_di;
    logic        div_do;

    int checks   = 0;
    int failures = 0;

    freq_div_ctrl #(.N(16), .NREQ(4), .CW(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_div (req_div),
        .req_cnt (req_cnt),
        .grant   (grant),
        .done    (done),
        .abort   (abort),
        .busy    (busy),
        .div_en  (div_en),
        .div_pl  (div_pl),
        .div_di  (div_di),
        .div_do  (div_do)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] dv, input logic [7:0] cn);
        req_div[i*16 +: 16] = dv;
        req_cnt[i*8 +: 8]   = cn;
    endtask

    // Bounded wait: a grant that never shows returns 0 and fails the caller's check.
    task automatic wait_grant(output logic [3:0] g);
        g = '0;
        for (int i = 0; i < 20 && g == '0; i++) begin
            tick(1);
            g = grant;
        end
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] rr_exp [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        rst_n   = 1'b0;
        req     = '0;
        req_div = '0;
        req_cnt = '0;
        div_do  = 1'b0;
        tick(2);
        chk("reset_outputs", {grant, done, abort, busy, div_en, div_pl, div_di}, 32'h0);
        rst_n = 1'b1;
        tick(1);

        // single request, divisor 3, four toggles
        set_req(0, 16'd3, 8'd4);
        req = 4'b0001;
        wait_grant(g);
        chk("single_grant", g, 4'b0001);
        chk("single_pl", div_pl, 1'b1);
        chk("single_di", div_di, 16'd3);
        chk("single_en_load", div_en, 1'b1);
        chk("single_busy", busy, 1'b1);
        tick(1);
        chk("single_pl_off", div_pl, 1'b0);
        for (int t = 0; t < 4; t++) begin
            tick(2);
            chk("single_en_run", div_en, 1'b1);
            chk("single_no_done", done, 1'b0);
            div_do = ~div_do;
            if (t < 3) tick(1);
        end
        tick(1);
        chk("single_done", done, 1'b1);
        chk("single_abort", abort, 1'b0);
        chk("single_en_done", div_en, 1'b0);
        chk("single_grant_done", grant, 4'b0000);
        req = '0;
        tick(1);
        chk("single_done_pulse", done, 1'b0);
        chk("single_idle_grant", grant, 4'b0000);
        chk("single_idle_busy", busy, 1'b0);

        // round robin from a fresh reset, all requesting, count 1
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 16'd2, 8'd1);
        req = 4'b1111;
        tick(1);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_grant(g);
            chk("rr_grant", g, rr_exp[i]);
            tick(1);
            div_do = ~div_do;
            tick(1);
            chk("rr_done", done, 1'b1);
            chk("rr_grant_off", grant, 4'b0000);
        end
        req = '0;
        tick(2);

        // abort: requester 2 drops after 3 of 10 toggles
        set_req(2, 16'd5, 8'd10);
        req = 4'b0100;
        wait_grant(g);
        chk("abort_grant", g, 4'b0100);
        tick(1);
        repeat (3) begin
            div_do = ~div_do;
            tick(2);
        end
        chk("abort_en_before", div_en, 1'b1);
        chk("abort_none_before", abort, 1'b0);
        req = '0;
        tick(1);
        chk("abort_pulse", abort, 1'b1);
        chk("abort_no_done", done, 1'b0);
        chk("abort_en_off", div_en, 1'b0);
        chk("abort_grant_off", grant, 4'b0000);
        tick(1);
        chk("abort_pulse_end", abort, 1'b0);
        tick(1);

        // final toggle coincides with request drop: completion wins
        set_req(1, 16'd4, 8'd2);
        req = 4'b0010;
        wait_grant(g);
        chk("tie_grant", g, 4'b0010);
        tick(1);
        div_do = ~div_do;
        tick(2);
        div_do = ~div_do;
        req    = '0;
        tick(1);
        chk("tie_done", done, 1'b1);
        chk("tie_abort", abort, 1'b0);
        tick(2);

        // divisor 0 clamps to 1; count 0 free-runs until req drops
        set_req(3, 16'd0, 8'd0);
        req = 4'b1000;
        wait_grant(g);
        chk("free_grant", g, 4'b1000);
        chk("free_di_clamp", div_di, 16'd1);
        tick(1);
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) div_do = ~div_do;
            tick(1);
        end
        chk("free_en_run", div_en, 1'b1);
        chk("free_no_done", done, 1'b0);
        chk("free_busy", busy, 1'b1);
        req = '0;
        tick(1);
        chk("free_done", done, 1'b1);
        chk("free_abort", abort, 1'b0);
        tick(2);

        // asynchronous reset in the middle of RUN
        set_req(0, 16'd7, 8'd10);
        req = 4'b0001;
        wait_grant(g);
        chk("mid_grant", g, 4'b0001);
        tick(1);
        div_do = ~div_do;
        tick(1);
        chk("mid_en_run", div_en, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", {grant, done, abort, busy, div_en, div_pl, div_di}, 32'h0);
        req = 4'b1001;
        tick(2);
        chk("mid_reset_held", {grant, done, abort, busy, div_en, div_pl, div_di}, 32'h0);
        rst_n = 1'b1;
        wait_grant(g);
        chk("post_reset_grant", g, 4'b0001);
        req = '0;
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
